display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan.sv | 111 +++++++++++
 tb/tb_display_scan.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// Four-digit multiplexed 7-segment scanner with frame-synchronous value updates.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module display_scan #(
    parameter int PRESCALE = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic        load,
    output logic [1:0]  digit_sel,
    output logic [6:0]  segments,
    output logic        update_pending,
    output logic        frame_done
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] count;
    logic             tick;
    logic             boundary;
    logic [1:0]       digit_next;
    logic [15:0]      shadow;
    logic [15:0]      display;
    logic [15:0]      display_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    function automatic logic [3:0] nibble_at(input logic [15:0] v, input logic [1:0] idx);
        return v[{idx, 2'b00} +: 4];
    endfunction

    // Pattern for one digit slot; blanking only ever hides digits above the top nonzero nibble.
    function automatic logic [6:0] digit_pattern(input logic [15:0] v, input logic [1:0] idx);
`ifdef LEADING_ZERO_BLANK_EN
        logic blank;
        case (idx)
            2'd1:    blank = (v[15:4] == 12'h000);
            2'd2:    blank = (v[15:8] == 8'h00);
            2'd3:    blank = (v[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
        return blank ? 7'h7F : hex_to_seg(nibble_at(v, idx));
`else
        return hex_to_seg(nibble_at(v, idx));
`endif
    endfunction

    always_comb begin
        tick         = (count == CNT_MAX);
        boundary     = tick && (digit_sel == 2'd3);
        digit_next   = digit_sel + 2'd1;
        display_next = display;
        // A load on the boundary tick is newer than anything in the shadow.
        if (boundary) begin
            if (load)
                display_next = value_in;
            else if (update_pending)
                display_next = shadow;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count          <= '0;
            digit_sel      <= 2'd0;
            segments       <= 7'h40;
            frame_done     <= 1'b0;
            display        <= 16'h0000;
            shadow         <= 16'h0000;
            update_pending <= 1'b0;
        end else begin
            count      <= tick ? '0 : count + CNT_W'(1);
            frame_done <= boundary;
            display    <= display_next;
            // Segments follow the digit index on the same edge, using the post-update value.
            if (tick) begin
                digit_sel <= digit_next;
                segments  <= digit_pattern(display_next, digit_next);
            end
            if (load && !boundary) begin
                shadow         <= value_in;
                update_pending <= 1'b1;
            end else if (boundary) begin
                update_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan: scan timing, deferred/colliding/overwritten loads,
// mid-frame reset and leading-zero blanking (expectations follow LEADING_ZERO_BLANK_EN).
module tb_display_scan;

    localparam int PRESCALE = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZB = 7'h7F;
`else
    localparam logic [6:0] ZB = 7'h40;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_in;
    logic        load;
    logic [1:0]  digit_sel;
    logic [6:0]  segments;
    logic        update_pending;
    logic        frame_done;

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    logic [6:0] exp_q[$];

    display_scan #(.PRESCALE(PRESCALE)) dut (
        .clk            (clk),
        .rst            (rst),
        .value_in       (value_in),
        .load           (load),
        .digit_sel      (digit_sel),
        .segments       (segments),
        .update_pending (update_pending),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_load(input logic [15:0] v);
        value_in = v;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic push4(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        exp_q.push_back(s0);
        exp_q.push_back(s1);
        exp_q.push_back(s2);
        exp_q.push_back(s3);
    endtask

    task automatic wait_frame(input string tag);
        for (int i = 0; i < 64; i++) begin
            if (frame_done === 1'b1) break;
            @(negedge clk);
        end
        check({tag, "_frame_done"}, 16'(frame_done), 16'd1);
    endtask

    // Waits for the next frame start and compares each digit slot against the scoreboard.
    task automatic check_frame(input string tag);
        logic [6:0] e;
        wait_frame(tag);
        for (int d = 0; d < 4; d++) begin
            if (d > 0) tick_n(PRESCALE);
            e = 7'bxxxxxxx;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            check({tag, "_sel"}, 16'(digit_sel), 16'(d));
            check({tag, "_seg"}, 16'(segments), 16'(e));
            check({tag, "_pending"}, 16'(update_pending), 16'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        value_in = 16'h0000;
        tick_n(2);
        check("rst_sel", 16'(digit_sel), 16'd0);
        check("rst_seg", 16'(segments), 16'h40);
        check("rst_pending", 16'(update_pending), 16'd0);
        check("rst_frame_done", 16'(frame_done), 16'd0);

        // Free-running scan with no load.
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            check("scan_sel", 16'(digit_sel), 16'((k / 4) % 4));
            check("scan_seg", 16'(segments), 16'(((k / 4) % 4 == 0) ? 7'h40 : ZB));
            check("scan_frame_done", 16'(frame_done), 16'(k % 16 == 0));
        end

        // Deferred update: load in digit 1 slot, visible only from the next frame.
        wait_frame("sync1");
        tick_n(5);
        pulse_load(16'h1234);
        check("defer_pending_set", 16'(update_pending), 16'd1);
        check("defer_sel", 16'(digit_sel), 16'd1);
        tick_n(6);
        check("defer_pending_hold", 16'(update_pending), 16'd1);
        check("defer_old_seg", 16'(segments), 16'(ZB));
        push4(7'h19, 7'h30, 7'h24, 7'h79);
        check_frame("defer");

        // Collision: load exactly on the boundary tick cycle (frame cycle 15).
        tick_n(3);
        check("coll_pre_sel", 16'(digit_sel), 16'd3);
        pulse_load(16'hABCD);
        push4(7'h21, 7'h46, 7'h03, 7'h08);
        check_frame("collision");
        push4(7'h21, 7'h46, 7'h03, 7'h08);
        check_frame("collision_hold");

        // Overwrite: two loads in one frame, only the last survives.
        wait_frame("sync2");
        tick_n(2);
        pulse_load(16'h1111);
        tick_n(3);
        pulse_load(16'h2222);
        check("over_pending", 16'(update_pending), 16'd1);
        push4(7'h24, 7'h24, 7'h24, 7'h24);
        check_frame("overwrite");

        // Reset mid-frame with an update pending.
        wait_frame("sync3");
        tick_n(2);
        pulse_load(16'h5678);
        tick_n(6);
        check("mrst_pre_pending", 16'(update_pending), 16'd1);
        check("mrst_pre_sel", 16'(digit_sel), 16'd2);
        #2 rst = 1'b1;
        #1;
        check("mrst_sel", 16'(digit_sel), 16'd0);
        check("mrst_seg", 16'(segments), 16'h40);
        check("mrst_pending", 16'(update_pending), 16'd0);
        check("mrst_frame_done", 16'(frame_done), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        push4(7'h40, ZB, ZB, ZB);
        check_frame("post_reset");

        // Leading-zero value.
        pulse_load(16'h0050);
        push4(7'h40, 7'h12, ZB, ZB);
        check_frame("blank");

        check("sb_empty", 16'(exp_q.size()), 16'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
